// File: rtl/toy_redirect_ctrl.sv
// Serializes branch, trap, debug and xRET change-of-flow requests into one
// fetch redirect, then holds pc_lock through a short drain window.
module toy_redirect_ctrl #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DRAIN_CYCLES  = 2,
    parameter logic [ADDR_WIDTH-1:0] DEBUG_PC_ADDR = ADDR_WIDTH'(32'h0000_0800),
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  br_vld,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    output logic                  br_rdy,
    input  logic                  trap_vld,
    input  logic [ADDR_WIDTH-1:0] trap_pc,
    output logic                  trap_rdy,
    input  logic                  dbg_vld,
    output logic                  dbg_rdy,
    input  logic                  xret_vld,
    input  logic [1:0]            xret_type,
    output logic                  xret_rdy,
    input  logic [ADDR_WIDTH-1:0] csr_mepc,
    input  logic [ADDR_WIDTH-1:0] csr_dpc,
    output logic                  redir_vld,
    output logic [ADDR_WIDTH-1:0] redir_pc,
    output logic [1:0]            redir_src,
    input  logic                  redir_rdy,
    output logic                  pc_lock,
    output logic [CNT_WIDTH-1:0]  redir_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    localparam logic [1:0] SRC_BR   = 2'd0;
    localparam logic [1:0] SRC_TRAP = 2'd1;
    localparam logic [1:0] SRC_DBG  = 2'd2;
    localparam logic [1:0] SRC_XRET = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                  state;
    logic [DRAIN_W-1:0]      drain_cnt;

    logic                    dbg_win;
    logic                    trap_win;
    logic                    xret_win;
    logic                    br_win;
    logic                    any_vld;
    logic                    in_idle;
    logic                    preempt;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic [1:0]              next_src;

    // Fixed priority dbg > trap > xret > br.
    assign dbg_win  = dbg_vld;
    assign trap_win = trap_vld & ~dbg_vld;
    assign xret_win = xret_vld & ~dbg_vld & ~trap_vld;
    assign br_win   = br_vld & ~dbg_vld & ~trap_vld & ~xret_vld;
    assign any_vld  = dbg_vld | trap_vld | xret_vld | br_vld;

    assign in_idle = (state == IDLE);
    // A pending branch redirect may be replaced by debug entry, but only if
    // fetch has not already taken the branch this cycle.
    assign preempt = (state == ISSUE) && (redir_src == SRC_BR) && dbg_vld && !redir_rdy;

    assign dbg_rdy  = !rst && ((in_idle && dbg_win) || preempt);
    assign trap_rdy = !rst && in_idle && trap_win;
    assign xret_rdy = !rst && in_idle && xret_win;
    assign br_rdy   = !rst && in_idle && br_win;

    always_comb begin
        next_pc  = br_pc;
        next_src = SRC_BR;
        if (dbg_win) begin
            next_pc  = DEBUG_PC_ADDR;
            next_src = SRC_DBG;
        end else if (trap_win) begin
            next_pc  = trap_pc;
            next_src = SRC_TRAP;
        end else if (xret_win) begin
            next_pc  = (xret_type == 2'b10) ? csr_dpc : csr_mepc;
            next_src = SRC_XRET;
        end
    end

    assign redir_vld = (state == ISSUE);
    assign pc_lock   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            redir_pc  <= '0;
            redir_src <= SRC_BR;
            redir_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        redir_pc  <= next_pc;
                        redir_src <= next_src;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (redir_rdy) begin
                        if (redir_cnt != {CNT_WIDTH{1'b1}}) begin
                            redir_cnt <= redir_cnt + CNT_WIDTH'(1);
                        end
                        if (DRAIN_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end else if (preempt) begin
                        redir_pc  <= DEBUG_PC_ADDR;
                        redir_src <= SRC_DBG;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DRAIN_W'(1);
                    if (drain_cnt == DRAIN_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toy_redirect_ctrl.sv
// Directed bench for toy_redirect_ctrl: one default instance and one
// DRAIN_CYCLES=0 / 2-bit counter instance for back-to-back and saturation.
module tb_toy_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_vld, trap_vld, dbg_vld, xret_vld, redir_rdy;
  logic [31:0] br_pc, trap_pc, csr_mepc, csr_dpc;
  logic [1:0]  xret_type;
  logic        br_rdy, trap_rdy, dbg_rdy, xret_rdy, redir_vld, pc_lock;
  logic [31:0] redir_pc;
  logic [1:0]  redir_src;
  logic [15:0] redir_cnt;

  logic        b1_vld, r1_rdy;
  logic [31:0] b1_pc;
  logic        b1_rdy, u1_trap_rdy, u1_dbg_rdy, u1_xret_rdy, u1_vld, u1_lock;
  logic [31:0] u1_pc;
  logic [1:0]  u1_src;
  logic [1:0]  u1_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  toy_redirect_ctrl u0 (
    .clk(clk), .rst(rst),
    .br_vld(br_vld), .br_pc(br_pc), .br_rdy(br_rdy),
    .trap_vld(trap_vld), .trap_pc(trap_pc), .trap_rdy(trap_rdy),
    .dbg_vld(dbg_vld), .dbg_rdy(dbg_rdy),
    .xret_vld(xret_vld), .xret_type(xret_type), .xret_rdy(xret_rdy),
    .csr_mepc(csr_mepc), .csr_dpc(csr_dpc),
    .redir_vld(redir_vld), .redir_pc(redir_pc), .redir_src(redir_src),
    .redir_rdy(redir_rdy), .pc_lock(pc_lock), .redir_cnt(redir_cnt)
  );

  toy_redirect_ctrl #(.DRAIN_CYCLES(0), .CNT_WIDTH(2)) u1 (
    .clk(clk), .rst(rst),
    .br_vld(b1_vld), .br_pc(b1_pc), .br_rdy(b1_rdy),
    .trap_vld(1'b0), .trap_pc(32'h0), .trap_rdy(u1_trap_rdy),
    .dbg_vld(1'b0), .dbg_rdy(u1_dbg_rdy),
    .xret_vld(1'b0), .xret_type(2'b00), .xret_rdy(u1_xret_rdy),
    .csr_mepc(32'h0), .csr_dpc(32'h0),
    .redir_vld(u1_vld), .redir_pc(u1_pc), .redir_src(u1_src),
    .redir_rdy(r1_rdy), .pc_lock(u1_lock), .redir_cnt(u1_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake an xRET in IDLE, check decoded target, then wait out ISSUE+DRAIN.
  task automatic xret_case(input logic [1:0] typ, input logic [31:0] mepc,
                           input logic [31:0] dpc, input logic [31:0] exp_pc);
    tick();
    xret_vld = 1'b1; xret_type = typ; csr_mepc = mepc; csr_dpc = dpc;
    redir_rdy = 1'b1;
    #1;
    chk("xret_rdy", xret_rdy, 1'b1, xret_rdy === 1'b1);
    tick();
    xret_vld = 1'b0;
    #1;
    chk("xret_pc", redir_pc, exp_pc, redir_pc === exp_pc);
    chk("xret_src", redir_src, 2'd3, redir_src === 2'd3);
    tick(); tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    br_vld = 1'b1; trap_vld = 1'b0; dbg_vld = 1'b0; xret_vld = 1'b0;
    redir_rdy = 1'b0; br_pc = 32'h0; trap_pc = 32'h0;
    csr_mepc = 32'h0; csr_dpc = 32'h0; xret_type = 2'b00;
    b1_vld = 1'b0; b1_pc = 32'h0; r1_rdy = 1'b0;
    #2;
    chk("rst_vld", redir_vld, 1'b0, redir_vld === 1'b0);
    chk("rst_pc", redir_pc, 32'h0, redir_pc === 32'h0);
    chk("rst_src", redir_src, 2'd0, redir_src === 2'd0);
    chk("rst_lock", pc_lock, 1'b0, pc_lock === 1'b0);
    chk("rst_cnt", redir_cnt, 16'h0, redir_cnt === 16'h0);
    chk("rst_br_rdy", br_rdy, 1'b0, br_rdy === 1'b0);
    chk("rst_u1_cnt", u1_cnt, 2'd0, u1_cnt === 2'd0);
    br_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Single branch
    tick();
    br_vld = 1'b1; br_pc = 32'h100; redir_rdy = 1'b1;
    #1;
    chk("t1_br_rdy", br_rdy, 1'b1, br_rdy === 1'b1);
    chk("t1_lock_c0", pc_lock, 1'b0, pc_lock === 1'b0);
    tick();
    br_vld = 1'b0;
    #1;
    chk("t1_vld", redir_vld, 1'b1, redir_vld === 1'b1);
    chk("t1_pc", redir_pc, 32'h100, redir_pc === 32'h100);
    chk("t1_src", redir_src, 2'd0, redir_src === 2'd0);
    chk("t1_lock_c1", pc_lock, 1'b1, pc_lock === 1'b1);
    tick();
    chk("t1_vld_c2", redir_vld, 1'b0, redir_vld === 1'b0);
    chk("t1_lock_c2", pc_lock, 1'b1, pc_lock === 1'b1);
    chk("t1_cnt", redir_cnt, 16'd1, redir_cnt === 16'd1);
    tick();
    chk("t1_lock_c3", pc_lock, 1'b1, pc_lock === 1'b1);
    tick();
    chk("t1_lock_c4", pc_lock, 1'b0, pc_lock === 1'b0);

    // Simultaneous requests: dbg, trap, xret, br
    tick();
    dbg_vld = 1'b1; trap_vld = 1'b1; trap_pc = 32'h200;
    xret_vld = 1'b1; xret_type = 2'b01; csr_mepc = 32'h300; csr_dpc = 32'h999;
    br_vld = 1'b1; br_pc = 32'h100; redir_rdy = 1'b1;
    #1;
    chk("t2_dbg_rdy", dbg_rdy, 1'b1, dbg_rdy === 1'b1);
    chk("t2_trap_rdy0", trap_rdy, 1'b0, trap_rdy === 1'b0);
    chk("t2_xret_rdy0", xret_rdy, 1'b0, xret_rdy === 1'b0);
    chk("t2_br_rdy0", br_rdy, 1'b0, br_rdy === 1'b0);
    tick();
    dbg_vld = 1'b0;
    #1;
    chk("t2_dbg_pc", redir_pc, 32'h800, redir_pc === 32'h800);
    chk("t2_dbg_src", redir_src, 2'd2, redir_src === 2'd2);
    chk("t2_trap_rdy_issue", trap_rdy, 1'b0, trap_rdy === 1'b0);
    tick();
    chk("t2_trap_rdy_drain", trap_rdy, 1'b0, trap_rdy === 1'b0);
    tick(); tick();
    chk("t2_trap_rdy", trap_rdy, 1'b1, trap_rdy === 1'b1);
    chk("t2_xret_rdy1", xret_rdy, 1'b0, xret_rdy === 1'b0);
    tick();
    trap_vld = 1'b0;
    #1;
    chk("t2_trap_pc", redir_pc, 32'h200, redir_pc === 32'h200);
    chk("t2_trap_src", redir_src, 2'd1, redir_src === 2'd1);
    tick(); tick(); tick();
    chk("t2_xret_rdy", xret_rdy, 1'b1, xret_rdy === 1'b1);
    chk("t2_br_rdy1", br_rdy, 1'b0, br_rdy === 1'b0);
    tick();
    xret_vld = 1'b0;
    #1;
    chk("t2_xret_pc", redir_pc, 32'h300, redir_pc === 32'h300);
    chk("t2_xret_src", redir_src, 2'd3, redir_src === 2'd3);
    tick(); tick(); tick();
    chk("t2_br_rdy", br_rdy, 1'b1, br_rdy === 1'b1);
    tick();
    br_vld = 1'b0;
    #1;
    chk("t2_br_pc", redir_pc, 32'h100, redir_pc === 32'h100);
    chk("t2_br_src", redir_src, 2'd0, redir_src === 2'd0);
    tick(); tick(); tick();
    chk("t2_cnt", redir_cnt, 16'd5, redir_cnt === 16'd5);
    chk("t2_lock_end", pc_lock, 1'b0, pc_lock === 1'b0);

    // Backpressure then debug preemption
    tick();
    br_vld = 1'b1; br_pc = 32'h100; redir_rdy = 1'b0;
    #1;
    chk("t3_br_rdy", br_rdy, 1'b1, br_rdy === 1'b1);
    tick();
    br_vld = 1'b0;
    #1;
    chk("t3_vld_c1", redir_vld, 1'b1, redir_vld === 1'b1);
    tick(); tick();
    chk("t3_vld_c3", redir_vld, 1'b1, redir_vld === 1'b1);
    chk("t3_pc_c3", redir_pc, 32'h100, redir_pc === 32'h100);
    tick();
    dbg_vld = 1'b1;
    #1;
    chk("t3_dbg_rdy", dbg_rdy, 1'b1, dbg_rdy === 1'b1);
    tick();
    dbg_vld = 1'b0;
    #1;
    chk("t3_pre_pc", redir_pc, 32'h800, redir_pc === 32'h800);
    chk("t3_pre_src", redir_src, 2'd2, redir_src === 2'd2);
    chk("t3_pre_vld", redir_vld, 1'b1, redir_vld === 1'b1);
    chk("t3_cnt_hold", redir_cnt, 16'd5, redir_cnt === 16'd5);
    redir_rdy = 1'b1;
    tick();
    chk("t3_cnt", redir_cnt, 16'd6, redir_cnt === 16'd6);
    tick(); tick();
    chk("t3_lock_end", pc_lock, 1'b0, pc_lock === 1'b0);

    // Debug arriving in the same cycle fetch accepts the branch
    tick();
    br_vld = 1'b1; br_pc = 32'h120; redir_rdy = 1'b1;
    tick();
    br_vld = 1'b0; dbg_vld = 1'b1;
    #1;
    chk("t3b_dbg_rdy0", dbg_rdy, 1'b0, dbg_rdy === 1'b0);
    chk("t3b_pc", redir_pc, 32'h120, redir_pc === 32'h120);
    tick();
    chk("t3b_cnt", redir_cnt, 16'd7, redir_cnt === 16'd7);
    chk("t3b_dbg_rdy_drain", dbg_rdy, 1'b0, dbg_rdy === 1'b0);
    tick(); tick();
    chk("t3b_dbg_rdy_idle", dbg_rdy, 1'b1, dbg_rdy === 1'b1);
    tick();
    dbg_vld = 1'b0;
    #1;
    chk("t3b_dbg_pc", redir_pc, 32'h800, redir_pc === 32'h800);
    tick(); tick(); tick();
    chk("t3b_cnt_end", redir_cnt, 16'd8, redir_cnt === 16'd8);

    // xRET target decode
    xret_case(2'b10, 32'h500, 32'h440, 32'h440);
    xret_case(2'b11, 32'h500, 32'h440, 32'h500);
    xret_case(2'b00, 32'h600, 32'h440, 32'h600);
    chk("t4_cnt", redir_cnt, 16'd11, redir_cnt === 16'd11);

    // DRAIN_CYCLES=0 instance: back-to-back branches, then saturation
    tick();
    b1_vld = 1'b1; b1_pc = 32'h40; r1_rdy = 1'b1;
    #1;
    chk("t5_rdy_c0", b1_rdy, 1'b1, b1_rdy === 1'b1);
    tick();
    b1_pc = 32'h44;
    #1;
    chk("t5_vld_c1", u1_vld, 1'b1, u1_vld === 1'b1);
    chk("t5_pc_c1", u1_pc, 32'h40, u1_pc === 32'h40);
    chk("t5_lock_c1", u1_lock, 1'b1, u1_lock === 1'b1);
    chk("t5_rdy_c1", b1_rdy, 1'b0, b1_rdy === 1'b0);
    tick();
    chk("t5_lock_c2", u1_lock, 1'b0, u1_lock === 1'b0);
    chk("t5_vld_c2", u1_vld, 1'b0, u1_vld === 1'b0);
    chk("t5_rdy_c2", b1_rdy, 1'b1, b1_rdy === 1'b1);
    chk("t5_cnt_c2", u1_cnt, 2'd1, u1_cnt === 2'd1);
    tick();
    b1_vld = 1'b0;
    #1;
    chk("t5_vld_c3", u1_vld, 1'b1, u1_vld === 1'b1);
    chk("t5_pc_c3", u1_pc, 32'h44, u1_pc === 32'h44);
    tick();
    chk("t5_lock_c4", u1_lock, 1'b0, u1_lock === 1'b0);
    chk("t5_cnt_c4", u1_cnt, 2'd2, u1_cnt === 2'd2);
    b1_vld = 1'b1; b1_pc = 32'h48;
    tick();
    b1_vld = 1'b0;
    tick();
    chk("t5_cnt_max", u1_cnt, 2'd3, u1_cnt === 2'd3);
    b1_vld = 1'b1; b1_pc = 32'h4c;
    tick();
    b1_vld = 1'b0;
    tick();
    chk("t5_cnt_sat", u1_cnt, 2'd3, u1_cnt === 2'd3);
    chk("t5_pc_last", u1_pc, 32'h4c, u1_pc === 32'h4c);

    // Reset in the middle of ISSUE
    tick();
    br_vld = 1'b1; br_pc = 32'h700; redir_rdy = 1'b0;
    tick();
    br_vld = 1'b0;
    #1;
    chk("t6_vld_pre", redir_vld, 1'b1, redir_vld === 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_vld", redir_vld, 1'b0, redir_vld === 1'b0);
    chk("t6_pc", redir_pc, 32'h0, redir_pc === 32'h0);
    chk("t6_lock", pc_lock, 1'b0, pc_lock === 1'b0);
    chk("t6_cnt", redir_cnt, 16'h0, redir_cnt === 16'h0);
    br_vld = 1'b1;
    #1;
    chk("t6_br_rdy", br_rdy, 1'b0, br_rdy === 1'b0);
    br_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    redir_rdy = 1'b1;
    tick();
    chk("t6_vld_post1", redir_vld, 1'b0, redir_vld === 1'b0);
    tick();
    chk("t6_vld_post2", redir_vld, 1'b0, redir_vld === 1'b0);
    chk("t6_lock_post", pc_lock, 1'b0, pc_lock === 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
